// File: rtl/xor_frame_accum.sv
// Streaming XOR reduction: folds a frame of words into one XOR word, parity and beat count.
// Optional macro XOR_CHECK_EN adds an expected-XOR compare (in_check / out_match).
module xor_frame_accum #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16,
  localparam int BW       = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
`ifdef XOR_CHECK_EN
  input  logic [WIDTH-1:0] in_check,
  output logic             out_match,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_xor,
  output logic             out_parity,
  output logic [BW-1:0]    out_beats,
  output logic             out_overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, acc_n;
  logic [BW-1:0]    cnt_q, cnt_d, cnt_n;
  logic [WIDTH-1:0] xor_q, xor_d;
  logic             par_q, par_d;
  logic [BW-1:0]    beats_q, beats_d;
  logic             ovf_q, ovf_d;
  logic             take, close;
`ifdef XOR_CHECK_EN
  logic             match_q, match_d;
`endif

  assign in_ready = (state_q != S_HOLD);
  assign take     = in_valid && in_ready;

  // First beat of a frame replaces the accumulator instead of folding into it
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_n = in_data;
      cnt_n = BW'(1);
    end else begin
      acc_n = acc_q ^ in_data;
      cnt_n = cnt_q + BW'(1);
    end
  end

  assign close = take && (in_last || cnt_n == BW'(MAX_BEATS));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    xor_d   = xor_q;
    par_d   = par_q;
    beats_d = beats_q;
    ovf_d   = ovf_q;
`ifdef XOR_CHECK_EN
    match_d = match_q;
`endif
    unique case (state_q)
      S_IDLE, S_ACCUM: begin
        if (take) begin
          acc_d   = acc_n;
          cnt_d   = cnt_n;
          state_d = S_ACCUM;
        end
        if (close) begin
          state_d = S_HOLD;
          xor_d   = acc_n;
          par_d   = ^acc_n;
          beats_d = cnt_n;
          ovf_d   = !in_last;
`ifdef XOR_CHECK_EN
          match_d = in_last && (acc_n == in_check);
`endif
        end
      end
      S_HOLD: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      xor_q   <= '0;
      par_q   <= 1'b0;
      beats_q <= '0;
      ovf_q   <= 1'b0;
`ifdef XOR_CHECK_EN
      match_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      xor_q   <= xor_d;
      par_q   <= par_d;
      beats_q <= beats_d;
      ovf_q   <= ovf_d;
`ifdef XOR_CHECK_EN
      match_q <= match_d;
`endif
    end
  end

  assign out_valid    = (state_q == S_HOLD);
  assign out_xor      = xor_q;
  assign out_parity   = par_q;
  assign out_beats    = beats_q;
  assign out_overflow = ovf_q;
`ifdef XOR_CHECK_EN
  assign out_match    = match_q;
`endif

endmodule

// File: doc/xor_frame_accum.md
Name: xor_frame_accum

Overview:
- Streaming XOR reduction unit: folds a frame of WIDTH-bit words into one WIDTH-bit XOR word plus a 1-bit overall parity.
- Parametrised successor to the two-input combinational XOR gate in the classwork set.
- Sits between a word source and a consumer.
- Both sides use valid/ready handshakes; results are registered.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- MAX_BEATS, 16, maximum beats per frame before forced close (>=2).
- BW, $clog2(MAX_BEATS+1), derived localparam: beat-count width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept a word.
- in_data  input  WIDTH  input word.
- in_last  input  1  marks final word of frame.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_xor  output  WIDTH  bitwise XOR of all accepted words in frame.
- out_parity  output  1  reduction XOR of out_xor (1 = odd number of set bits).
- out_beats  output  BW  number of words in frame (1..MAX_BEATS).
- out_overflow  output  1  frame force-closed at MAX_BEATS without in_last.

Behaviour:
- Interface: single clock clk; reset rst is synchronous, active-high.
- Reset:
  - state=IDLE; accumulator=0; beat count=0.
  - out_valid=0, out_xor=0, out_parity=0, out_beats=0, out_overflow=0.
  - in_ready=1 from the first cycle after reset.
- Transfer rules:
  - Input transfer occurs when in_valid&&in_ready at a clk edge.
  - Output transfer occurs when out_valid&&out_ready.
- States:
  - IDLE: in_ready=1. A transfer loads acc=in_data and cnt=1. If in_last=1, go to HOLD; else go to ACCUM.
  - ACCUM: in_ready=1. A transfer sets acc^=in_data and cnt+=1. Go to HOLD when in_last=1 or when the new cnt==MAX_BEATS.
  - HOLD: in_ready=0, out_valid=1. Outputs are stable until out_ready. An output transfer returns to IDLE.
- HOLD outputs:
  - out_xor = final acc.
  - out_parity = ^acc.
  - out_beats = final cnt.
  - out_overflow = 1 only if the close was caused by cnt reaching MAX_BEATS with in_last=0.
- Latency: out_valid rises the cycle after the closing input transfer. A 1-beat frame gives a result 1 cycle after acceptance.
- Throughput: one frame per (beats+1) cycles minimum. No input acceptance during HOLD and no bypass; acceptance restarts the cycle after the output transfer.
- Overflow: beat MAX_BEATS is included in the result. The next accepted word starts a new frame in IDLE, even if it carries in_last.
- in_last on beat MAX_BEATS: normal close, out_overflow=0.
- in_valid=0 in ACCUM: state and acc hold indefinitely; no timeout.
- Changes to in_data or in_last while in_valid=0 are ignored.
- Outputs while not HOLD: out_valid=0; other outputs hold their last values (0 after reset).
- Reset mid-frame or in HOLD: partial frame and pending result are discarded; reset values apply on the next cycle.
- Simultaneous rst and a transfer: rst wins, the word is dropped.
- Width: acc and out_xor are exactly WIDTH bits. cnt never exceeds MAX_BEATS (BW bits suffice).

Optional Feature:
- Macro: XOR_CHECK_EN.
- When defined:
  - Adds port in_check (input, WIDTH): expected XOR word, sampled only on the closing transfer (in_last=1).
  - Adds port out_match (output, 1): 1 in HOLD iff out_xor==sampled in_check.
  - out_match is 0 after reset and 0 on overflow closes.
- When undefined: neither port exists; behaviour is otherwise identical.

Test Plan:
- Reset then a 1-beat frame: in_data=8'hA5, in_last=1 → next cycle out_valid=1, out_xor=8'hA5, out_parity=0, out_beats=1, out_overflow=0.
- 4-beat frame 8'h01, 8'h02, 8'h04, 8'h08 (last on 4th), out_ready=1 → out_xor=8'h0F, out_parity=0, out_beats=4; in_ready=0 for exactly one cycle.
- Backpressure: 3-beat frame 8'hFF, 8'h0F, 8'h01 with out_ready=0 for 5 cycles → out_valid held, out_xor=8'hF1 (parity 1) stable, in_ready=0 throughout. A word offered during this time is not accepted until the cycle after out_ready=1.
- Overflow: MAX_BEATS=16, 16 beats of 8'h01 with in_last=0 → out_xor=8'h00, out_beats=16, out_overflow=1. Then a 17th word 8'h3C with last → new frame result 8'h3C, beats=1, overflow=0.
- Reset mid-frame: after 2 beats assert rst for 1 cycle, then send 8'h55 with last → out_xor=8'h55, out_beats=1 (earlier beats discarded). Check in_valid gaps in ACCUM do not alter acc.
- With XOR_CHECK_EN: frame 8'h12, 8'h34 with in_check=8'h26 → out_match=1. Repeat with in_check=8'h27 → out_match=0.
